layer_scheduler: RTL
====================

# layer_scheduler

Top-level sequencer for the CNN datapath. Holds a small table of layer descriptors and, after a start pulse, steps through them. For each layer it presents the layer type and weight base to the datapath, pulses the iterator's `go`, waits for its `ready`, then flips the ping-pong feature buffer. It sits between the host/testbench control and the iterator/conv/relu/max_pool chain.

## Interface
Parameters:
- MAX_LAYERS, 8, depth of the descriptor table.
- W_LIDX, $clog2(MAX_LAYERS), width of the layer index.
- SETTLE_CYCLES, 2, idle gap between layer `ready` and the next descriptor fetch. Legal range 1..15.
- TIMEOUT, 65535, WAIT-state cycle limit. Used only with LAYER_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous reset, active-low; one clock, sampled on the rising edge of clk.
- start  in  1  pulse; begins a run at layer 0. Ignored while busy.
- abort  in  1  pulse; ends the run with no done pulse.
- cfg_we  in  1  descriptor write strobe. Ignored while busy.
- cfg_addr  in  W_LIDX  descriptor index.
- cfg_data  in  20  descriptor: [1:0] kind (0 conv, 1 relu, 2 max_pool, 3 reserved), [2] last, [3] no_swap, [19:4] wbase.
- layer_go  out  1  one-cycle pulse to the iterator `go`.
- layer_ready  in  1  iterator `ready` pulse.
- layer_idx  out  W_LIDX  current layer.
- layer_kind  out  2  kind of the current layer.
- wbase  out  16  weight base address of the current layer.
- buf_sel  out  1  read bank; the write bank is ~buf_sel.
- busy  out  1  high from the cycle after start is accepted until the DONE state exits.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag. Constant 0 when LAYER_TIMEOUT_EN is not defined.

## Operation
- States: IDLE, FETCH, GO, WAIT, SETTLE, DONE.
- IDLE: start=1 → FETCH; layer_idx←0, buf_sel←0, err←0.
- FETCH (1 cycle): register the descriptor at layer_idx into layer_kind, wbase, and internal last/no_swap → GO.
- GO (1 cycle): layer_go=1 → WAIT.
- WAIT, layer_ready=1:
  - buf_sel toggles unless no_swap is set.
  - If last=1 or layer_idx==MAX_LAYERS-1 → DONE; otherwise → SETTLE.
- WAIT, layer_ready=0: stay in WAIT.
- SETTLE: counts SETTLE_CYCLES cycles. On the final cycle, layer_idx++ → FETCH.
- DONE (1 cycle): done=1 → IDLE.
- abort, any non-IDLE state → IDLE on the next edge. No done pulse. buf_sel and layer_idx hold their values. abort has priority over layer_ready in the same cycle.
- layer_ready outside WAIT is ignored, including in the GO cycle.
- start while busy is ignored. start and abort together in IDLE: start wins.
- cfg_we in IDLE writes the table the next edge. A write to the same index as a start in the same cycle is visible to FETCH.
- Reserved kind (3) is passed through unchanged; the scheduler does not check it.
- Reset: state=IDLE. layer_go=0, done=0, busy=0, err=0, buf_sel=0, layer_idx=0, layer_kind=0, wbase=0. The descriptor table is not reset. Reset asserted mid-run returns to IDLE at that edge, with no done pulse.

## Timing
- start sampled at edge k: busy=1 and FETCH in cycle k+1; layer_go=1 in cycle k+2.
- layer_ready sampled at edge r in WAIT:
  - Next layer: layer_go rises in cycle r+SETTLE_CYCLES+2.
  - Final layer: done=1 in cycle r+1, busy=0 in cycle r+2.
- layer_kind, wbase and layer_idx are stable from FETCH+1 until the next FETCH, so they are valid throughout layer_go and WAIT.
- All outputs are registered. No combinational path from input to output.

## Configuration
- LAYER_TIMEOUT_EN defined: a 16-bit counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT without layer_ready:
  - err←1 (sticky until the next accepted start or reset);
  - go to DONE, so done still pulses;
  - buf_sel does not toggle.
- LAYER_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; err tied to 0.

## Structure
- Package `cnn_sched_pkg` holds:
  - the state enum;
  - kind codes (KIND_CONV, KIND_RELU, KIND_POOL);
  - descriptor field offsets and the width 20.
- Sub-module `layer_desc_ram`: MAX_LAYERS×20 register file, one write port, one registered read port. It is read in FETCH.

## Test plan
- 3 layers (conv, relu, pool+last), iterator model returns ready 10 cycles after go:
  - exactly 3 layer_go pulses with layer_idx 0, 1, 2;
  - buf_sel 0→1→0→1;
  - one done pulse; busy spans the whole run.
- No layer has last set, MAX_LAYERS=8: the run ends after layer 7 with done; layer_idx=7 at done.
- abort in WAIT of layer 1 → IDLE on the next edge; no done pulse; a subsequent start restarts at layer 0 with buf_sel=0.
- start and layer_ready injected during busy, plus a cfg_we during busy: no effect on the sequence or the table contents.
- With LAYER_TIMEOUT_EN and TIMEOUT=20, ready never returned: err=1 and done=1 exactly 21 cycles after layer_go; err clears on the next start.
- rstn low for one cycle mid-SETTLE: all outputs take their reset values at that edge; the table keeps its contents; the next start runs correctly.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared definitions for the CNN layer scheduler: FSM state encoding,
// layer kind codes and the packed layer-descriptor layout.
//
// Descriptor layout (DESC_W = 20 bits):
//   [1:0]  kind    (conv / relu / max_pool / reserved)
//   [2]    last    final layer of the run
//   [3]    no_swap keep the ping-pong feature bank after this layer
//   [19:4] wbase   weight base address
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_GO     = 3'd2,
    S_WAIT   = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } sched_state_t;

  localparam logic [1:0] KIND_CONV = 2'd0;
  localparam logic [1:0] KIND_RELU = 2'd1;
  localparam logic [1:0] KIND_POOL = 2'd2;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  localparam int DESC_W          = 20;
  localparam int DESC_KIND_LSB   = 0;
  localparam int DESC_KIND_W     = 2;
  localparam int DESC_LAST_BIT   = 2;
  localparam int DESC_NOSWAP_BIT = 3;
  localparam int DESC_WBASE_LSB  = 4;
  localparam int DESC_WBASE_W    = 16;

  // Host-side helper for building a descriptor word.
  function automatic logic [DESC_W-1:0] pack_desc(
    input logic [1:0]  kind,
    input logic        last,
    input logic        no_swap,
    input logic [15:0] wbase
  );
    return {wbase, no_swap, last, kind};
  endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor table: DEPTH x DESC_W register file with one write port
// and one registered read port. Only the read register is reset; the table
// contents survive reset.
//
// Ports:
//   clk      clock, rising edge
//   rstn     synchronous active-low reset (read register only)
//   i_we     write strobe
//   i_waddr  write index
//   i_wdata  descriptor to write
//   i_re     read enable; o_rdata loads table[i_raddr] on the next edge
//   i_raddr  read index
//   o_rdata  registered read data
module layer_desc_ram
  import cnn_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DESC_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DESC_W-1:0] o_rdata
);

  logic [DESC_W-1:0] r_mem [DEPTH];
  logic [DESC_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/layer_scheduler.sv
// Top-level CNN layer sequencer. Steps through the descriptor table after a
// start pulse: fetch descriptor, pulse layer_go, wait for layer_ready, flip
// the ping-pong feature bank, settle, next layer.
//
// Optional feature macro: LAYER_TIMEOUT_EN -- bounds the WAIT state to
// TIMEOUT cycles, sets sticky err and finishes the run on expiry.
//
// Ports:
//   clk, rstn            clock / synchronous active-low reset
//   start, abort         run control pulses
//   cfg_we/addr/data     descriptor table write (IDLE only)
//   layer_go             one-cycle pulse to the iterator
//   layer_ready          iterator completion pulse
//   layer_idx/kind/wbase current layer descriptor
//   buf_sel              read bank of the feature buffer
//   busy, done, err      status
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | waiting for start; table writable
// S_FETCH  | descriptor at layer_idx read into output register
// S_GO     | layer_go asserted
// S_WAIT   | waiting for layer_ready (or timeout)
// S_SETTLE | SETTLE_CYCLES gap before fetching the next layer
// S_DONE   | done asserted for one cycle
module layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int MAX_LAYERS    = 8,
  parameter int W_LIDX        = $clog2(MAX_LAYERS),
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [W_LIDX-1:0] cfg_addr,
  input  logic [DESC_W-1:0] cfg_data,
  output logic              layer_go,
  input  logic              layer_ready,
  output logic [W_LIDX-1:0] layer_idx,
  output logic [1:0]        layer_kind,
  output logic [15:0]       wbase,
  output logic              buf_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [W_LIDX-1:0] LAST_IDX    = W_LIDX'(MAX_LAYERS - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic              r_go;
  logic              r_done;
  logic              r_busy;
  logic              r_buf_sel;
  logic [W_LIDX-1:0] r_idx;
  logic [3:0]        r_settle;
  logic [DESC_W-1:0] w_desc;
  logic              w_last;
  logic              w_no_swap;
  logic              w_cfg_we;
  logic              w_start_ok;
  logic              w_ready_ok;
  logic              w_settle_end;
  logic              w_timeout;

  assign w_cfg_we     = cfg_we && (r_state == S_IDLE);
  assign w_start_ok   = start && (r_state == S_IDLE);
  assign w_ready_ok   = (r_state == S_WAIT) && layer_ready && !abort;
  assign w_settle_end = (r_state == S_SETTLE) && (r_settle == 4'd0) && !abort;

  // The RAM read register doubles as the descriptor output register, so
  // kind/wbase change only on the edge that ends FETCH.
  layer_desc_ram #(
    .DEPTH (MAX_LAYERS),
    .AW    (W_LIDX)
  ) u_desc_ram (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_re    (r_state == S_FETCH),
    .i_raddr (r_idx),
    .o_rdata (w_desc)
  );

  assign w_last    = w_desc[DESC_LAST_BIT];
  assign w_no_swap = w_desc[DESC_NOSWAP_BIT];

`ifdef LAYER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_wait_cnt;
  logic        r_err;

  // Counts completed WAIT cycles; the expiry compare fires on the cycle whose
  // closing edge would bring the count to TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == TIMEOUT_LAST)
                     && !layer_ready && !abort;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_GO;
      S_GO:     w_next = S_WAIT;
      S_WAIT: begin
        if (layer_ready) begin
          w_next = (w_last || (r_idx == LAST_IDX)) ? S_DONE : S_SETTLE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_SETTLE: if (r_settle == 4'd0) w_next = S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // abort outranks everything once a run is in progress
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_buf_sel <= 1'b0;
      r_idx     <= '0;
      r_settle  <= '0;
    end else begin
      r_state <= w_next;
      // status outputs are registered copies of the next-state decode
      r_go    <= (w_next == S_GO);
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);

      if (w_start_ok) begin
        r_idx     <= '0;
        r_buf_sel <= 1'b0;
      end else begin
        if (w_settle_end) begin
          r_idx <= r_idx + W_LIDX'(1);
        end
        if (w_ready_ok && !w_no_swap) begin
          r_buf_sel <= ~r_buf_sel;
        end
      end

      if ((w_next == S_SETTLE) && (r_state != S_SETTLE)) begin
        r_settle <= SETTLE_LOAD;
      end else if ((r_state == S_SETTLE) && (r_settle != 4'd0)) begin
        r_settle <= r_settle - 4'd1;
      end
    end
  end

  assign layer_go   = r_go;
  assign done       = r_done;
  assign busy       = r_busy;
  assign buf_sel    = r_buf_sel;
  assign layer_idx  = r_idx;
  assign layer_kind = w_desc[DESC_KIND_LSB +: DESC_KIND_W];
  assign wbase      = w_desc[DESC_WBASE_LSB +: DESC_WBASE_W];

endmodule
